// File: rtl/axis_frame_fifo.sv
`default_nettype none
// ============================================================================
// Module : axis_frame_fifo
// AXI-Stream FIFO with cut-through (FRAME_MODE=0) or store-and-forward
// (FRAME_MODE=1) frame release and oversize-frame fallback.
// Rev    : 1.0
// ============================================================================
module axis_frame_fifo #(
  parameter int DATA_W     = 8,
  parameter int DEPTH      = 16,
  parameter int FRAME_MODE = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_W-1:0]      s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic                   s_last,
  output logic [DATA_W-1:0]      m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   m_last,
  output logic [$clog2(DEPTH):0] level,
  output logic [$clog2(DEPTH):0] frame_cnt,
  output logic                   oversize
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);
  localparam logic [AW:0] c_one   = (AW+1)'(1);

  logic [DATA_W:0]   mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       level_q, level_d;
  logic [AW:0]       fcnt_q, fcnt_d;
  logic              s_ready_q, s_ready_d;
  logic              oversize_q, oversize_d;
  logic              release_q, release_d;
  logic              wr_en, rd_en;

  assign wr_en = s_valid & s_ready_q;
  assign rd_en = m_valid & m_ready;

  assign {m_last, m_data} = mem_q[rd_ptr_q];

  // release_q keeps a frame flowing once its first beat has left, which also
  // lets an oversize frame drain cut-through until its last beat.
  assign m_valid = (level_q != '0) &&
                   ((FRAME_MODE == 0) || (fcnt_q != '0) ||
                    (level_q == c_depth) || release_q);

  assign s_ready   = s_ready_q;
  assign level     = level_q;
  assign frame_cnt = fcnt_q;
  assign oversize  = oversize_q;

  always_comb begin
    level_d = level_q;
    case ({wr_en, rd_en})
      2'b10:   level_d = level_q + c_one;
      2'b01:   level_d = level_q - c_one;
      default: level_d = level_q;
    endcase

    fcnt_d = fcnt_q;
    case ({wr_en & s_last, rd_en & m_last})
      2'b10:   fcnt_d = fcnt_q + c_one;
      2'b01:   fcnt_d = fcnt_q - c_one;
      default: fcnt_d = fcnt_q;
    endcase

    release_d = release_q;
    if (rd_en) begin
      release_d = ~m_last;
    end

    s_ready_d  = (level_d < c_depth);
    oversize_d = (FRAME_MODE != 0) && (level_d == c_depth) &&
                 (level_q != c_depth) && (fcnt_d == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      fcnt_q     <= '0;
      s_ready_q  <= 1'b0;
      oversize_q <= 1'b0;
      release_q  <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (rd_en) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      level_q    <= level_d;
      fcnt_q     <= fcnt_d;
      s_ready_q  <= s_ready_d;
      oversize_q <= oversize_d;
      release_q  <= release_d;
    end
  end

  // Payload storage carries no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= {s_last, s_data};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axis_frame_fifo.sv
`default_nettype none
// ============================================================================
// Module : tb_axis_frame_fifo
// Scoreboard bench driving a cut-through and a store-and-forward instance.
// Rev    : 1.0
// ============================================================================
module tb_axis_frame_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] ct_s_data = '0, sf_s_data = '0;
  logic          ct_s_valid = 1'b0, ct_s_last = 1'b0, ct_m_ready = 1'b0;
  logic          sf_s_valid = 1'b0, sf_s_last = 1'b0, sf_m_ready = 1'b0;
  logic [DW-1:0] ct_m_data, sf_m_data;
  logic          ct_s_ready, ct_m_valid, ct_m_last, ct_oversize;
  logic          sf_s_ready, sf_m_valid, sf_m_last, sf_oversize;
  logic [LW-1:0] ct_level, ct_frame_cnt, sf_level, sf_frame_cnt;

  axis_frame_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .FRAME_MODE(0)) u_ct (
    .clk(clk), .rst(rst),
    .s_data(ct_s_data), .s_valid(ct_s_valid), .s_ready(ct_s_ready), .s_last(ct_s_last),
    .m_data(ct_m_data), .m_valid(ct_m_valid), .m_ready(ct_m_ready), .m_last(ct_m_last),
    .level(ct_level), .frame_cnt(ct_frame_cnt), .oversize(ct_oversize)
  );

  axis_frame_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .FRAME_MODE(1)) u_sf (
    .clk(clk), .rst(rst),
    .s_data(sf_s_data), .s_valid(sf_s_valid), .s_ready(sf_s_ready), .s_last(sf_s_last),
    .m_data(sf_m_data), .m_valid(sf_m_valid), .m_ready(sf_m_ready), .m_last(sf_m_last),
    .level(sf_level), .frame_cnt(sf_frame_cnt), .oversize(sf_oversize)
  );

  int vec  = 0;
  int errs = 0;
  logic [DW:0] q_ct[$];
  logic [DW:0] q_sf[$];

  // Drive one cycle on the selected instance, push accepted beats to its
  // queue and pop the expected beat for any read about to happen.
  task automatic step(input bit sel, input logic v, input logic [DW-1:0] d,
                      input logic l, input logic r,
                      output logic wr, output logic rd,
                      output logic [DW:0] got, output logic [DW:0] ex);
    @(negedge clk);
    if (sel) begin
      sf_s_valid = v; sf_s_data = d; sf_s_last = l; sf_m_ready = r;
    end else begin
      ct_s_valid = v; ct_s_data = d; ct_s_last = l; ct_m_ready = r;
    end
    #1;
    if (sel) begin
      wr = v && sf_s_ready; rd = sf_m_valid && r; got = {sf_m_last, sf_m_data};
    end else begin
      wr = v && ct_s_ready; rd = ct_m_valid && r; got = {ct_m_last, ct_m_data};
    end
    ex = 'x;
    if (rd) begin
      if (sel && q_sf.size() > 0) ex = q_sf.pop_front();
      if (!sel && q_ct.size() > 0) ex = q_ct.pop_front();
    end
    if (wr) begin
      if (sel) q_sf.push_back({l, d});
      else     q_ct.push_back({l, d});
    end
  endtask

  task automatic quiet();
    @(negedge clk);
    ct_s_valid = 1'b0; sf_s_valid = 1'b0; ct_m_ready = 1'b0; sf_m_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    vec++;
    if ({ct_level, ct_frame_cnt, ct_m_valid, ct_s_ready, ct_oversize} !== '0) begin
      errs++; $display("FAIL reset_ct: got lvl=%0d fc=%0d mv=%b sr=%b ov=%b, need all 0",
                       ct_level, ct_frame_cnt, ct_m_valid, ct_s_ready, ct_oversize);
    end
    vec++;
    if ({sf_level, sf_frame_cnt, sf_m_valid, sf_s_ready, sf_oversize} !== '0) begin
      errs++; $display("FAIL reset_sf: got lvl=%0d fc=%0d mv=%b sr=%b ov=%b, need all 0",
                       sf_level, sf_frame_cnt, sf_m_valid, sf_s_ready, sf_oversize);
    end
    rst = 1'b1;
    #1;
    vec++;
    if ({ct_s_ready, sf_s_ready} !== 2'b00) begin
      errs++; $display("FAIL ready_before_edge: got %b need 00", {ct_s_ready, sf_s_ready});
    end
    @(negedge clk); #1;
    vec++;
    if ({ct_s_ready, sf_s_ready} !== 2'b11) begin
      errs++; $display("FAIL ready_after_edge: got %b need 11", {ct_s_ready, sf_s_ready});
    end
  endtask

  task automatic test_cut_through();
    logic wr, rd;
    logic [DW:0] got, ex;
    quiet();
    for (int i = 0; i < 10; i++) begin
      step(1'b0, i < 8, DW'($urandom), i == 7, 1'b1, wr, rd, got, ex);
      vec++;
      if (rd !== (i >= 1 && i <= 8)) begin
        errs++; $display("FAIL ct_latency cyc %0d: read=%b need %b", i, rd, (i >= 1 && i <= 8));
      end
      vec++;
      if (ct_level > 1) begin
        errs++; $display("FAIL ct_level_max cyc %0d: level=%0d need <=1", i, ct_level);
      end
      if (rd) begin
        vec++;
        if (got !== ex) begin
          errs++; $display("FAIL ct_data cyc %0d: got %h need %h", i, got, ex);
        end
      end
    end
  endtask

  task automatic test_full();
    logic wr, rd;
    logic [DW:0] got, ex;
    int k = 0, reads = 0;
    quiet();
    for (int c = 0; c < 20; c++) begin
      step(1'b0, 1'b1, DW'(8'h40 + k), k == 19, 1'b0, wr, rd, got, ex);
      if (wr) k++;
    end
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, wr, rd, got, ex);
    vec++;
    if (k !== 16) begin
      errs++; $display("FAIL full_accepted: got %0d need 16", k);
    end
    vec++;
    if (ct_level !== LW'(16) || ct_s_ready !== 1'b0) begin
      errs++; $display("FAIL full_state: level=%0d s_ready=%b need 16/0", ct_level, ct_s_ready);
    end
    for (int c = 0; c < 60 && reads < 20; c++) begin
      step(1'b0, k < 20, DW'(8'h40 + k), k == 19, 1'b1, wr, rd, got, ex);
      if (c == 0) begin
        vec++;
        if (ct_s_ready !== 1'b0 || rd !== 1'b1) begin
          errs++; $display("FAIL full_first_read: s_ready=%b read=%b need 0/1", ct_s_ready, rd);
        end
      end
      if (c == 1) begin
        vec++;
        if (ct_s_ready !== 1'b1) begin
          errs++; $display("FAIL full_ready_reopen: s_ready=%b need 1", ct_s_ready);
        end
      end
      if (wr) k++;
      if (rd) begin
        reads++;
        vec++;
        if (got !== ex) begin
          errs++; $display("FAIL full_data read %0d: got %h need %h", reads, got, ex);
        end
      end
    end
    vec++;
    if (reads !== 20 || k !== 20) begin
      errs++; $display("FAIL full_drain: reads=%0d accepted=%0d need 20/20", reads, k);
    end
  endtask

  task automatic test_store_forward();
    logic wr, rd;
    logic [DW:0] got, ex;
    quiet();
    for (int i = 0; i < 18; i++) begin
      step(1'b1, i < 8, DW'($urandom), i == 7, 1'b1, wr, rd, got, ex);
      if (i < 8) begin
        vec++;
        if (sf_m_valid !== 1'b0) begin
          errs++; $display("FAIL sf_hold cyc %0d: m_valid=%b need 0", i, sf_m_valid);
        end
      end
      if (i == 8) begin
        vec++;
        if (sf_frame_cnt !== LW'(1)) begin
          errs++; $display("FAIL sf_fcnt_one: got %0d need 1", sf_frame_cnt);
        end
      end
      if (i == 16) begin
        vec++;
        if (sf_frame_cnt !== '0) begin
          errs++; $display("FAIL sf_fcnt_zero: got %0d need 0", sf_frame_cnt);
        end
      end
      vec++;
      if (rd !== (i >= 8 && i <= 15)) begin
        errs++; $display("FAIL sf_burst cyc %0d: read=%b need %b", i, rd, (i >= 8 && i <= 15));
      end
      if (rd) begin
        vec++;
        if (got !== ex) begin
          errs++; $display("FAIL sf_data cyc %0d: got %h need %h", i, got, ex);
        end
      end
    end
  endtask

  task automatic test_oversize();
    logic wr, rd;
    logic [DW:0] got, ex;
    int k = 0, reads = 0, pulses = 0;
    quiet();
    for (int c = 0; c < 80 && reads < 20; c++) begin
      step(1'b1, k < 20, DW'(8'h80 + k), k == 19, 1'b1, wr, rd, got, ex);
      if (c < 16) begin
        vec++;
        if (sf_m_valid !== 1'b0) begin
          errs++; $display("FAIL ovs_hold cyc %0d: m_valid=%b need 0", c, sf_m_valid);
        end
      end
      if (sf_oversize) begin
        pulses++;
        vec++;
        if (sf_level !== LW'(16)) begin
          errs++; $display("FAIL ovs_level: level=%0d at pulse need 16", sf_level);
        end
      end
      if (wr) k++;
      if (rd) begin
        reads++;
        vec++;
        if (got !== ex) begin
          errs++; $display("FAIL ovs_data read %0d: got %h need %h", reads, got, ex);
        end
      end
    end
    vec++;
    if (pulses !== 1 || reads !== 20) begin
      errs++; $display("FAIL ovs_summary: pulses=%0d reads=%0d need 1/20", pulses, reads);
    end
  endtask

  task automatic test_simultaneous();
    logic wr, rd;
    logic [DW:0] got, ex;
    int reads = 0;
    quiet();
    step(1'b1, 1'b1, 8'hA0, 1'b1, 1'b0, wr, rd, got, ex);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, DW'(8'hB0 + i), 1'b0, 1'b0, wr, rd, got, ex);
    end
    step(1'b1, 1'b1, 8'hB4, 1'b1, 1'b1, wr, rd, got, ex);
    vec++;
    if (sf_level !== LW'(5) || sf_frame_cnt !== LW'(1) || !(wr && rd)) begin
      errs++; $display("FAIL sim_pre: level=%0d fc=%0d wr=%b rd=%b need 5/1/1/1",
                       sf_level, sf_frame_cnt, wr, rd);
    end
    vec++;
    if (got !== ex) begin
      errs++; $display("FAIL sim_data: got %h need %h", got, ex);
    end
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, wr, rd, got, ex);
    vec++;
    if (sf_level !== LW'(5) || sf_frame_cnt !== LW'(1)) begin
      errs++; $display("FAIL sim_post: level=%0d fc=%0d need 5/1", sf_level, sf_frame_cnt);
    end
    for (int c = 0; c < 12 && reads < 5; c++) begin
      step(1'b1, 1'b0, '0, 1'b0, 1'b1, wr, rd, got, ex);
      if (rd) begin
        reads++;
        vec++;
        if (got !== ex) begin
          errs++; $display("FAIL sim_drain read %0d: got %h need %h", reads, got, ex);
        end
      end
    end
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, wr, rd, got, ex);
    vec++;
    if (reads !== 5 || sf_frame_cnt !== '0 || sf_level !== '0) begin
      errs++; $display("FAIL sim_end: reads=%0d fc=%0d level=%0d need 5/0/0",
                       reads, sf_frame_cnt, sf_level);
    end
  endtask

  task automatic test_back_to_back();
    logic wr, rd;
    logic [DW:0] got, ex;
    logic [8:0] last_mask;
    last_mask = 9'b110110011;
    quiet();
    for (int s = 0; s < 2; s++) begin
      int k = 0, reads = 0;
      for (int c = 0; c < 100 && reads < 9; c++) begin
        step(s[0], k < 9, DW'($urandom), (k < 9) ? last_mask[k % 9] : 1'b0,
             1'($urandom_range(0, 1)), wr, rd, got, ex);
        if (wr) k++;
        if (rd) begin
          reads++;
          vec++;
          if (got !== ex) begin
            errs++; $display("FAIL b2b_data mode %0d read %0d: got %h need %h", s, reads, got, ex);
          end
        end
      end
      step(s[0], 1'b0, '0, 1'b0, 1'b0, wr, rd, got, ex);
      vec++;
      if (reads !== 9 || (s == 0 ? ct_level : sf_level) !== '0 ||
          (s == 0 ? ct_frame_cnt : sf_frame_cnt) !== '0) begin
        errs++; $display("FAIL b2b_end mode %0d: reads=%0d need 9 with empty fifo", s, reads);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic wr, rd;
    logic [DW:0] got, ex;
    int reads = 0;
    quiet();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, DW'(8'hC0 + i), 1'b0, 1'b0, wr, rd, got, ex);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, wr, rd, got, ex);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, DW'(8'hD0 + i), 1'b0, 1'b0, wr, rd, got, ex);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, wr, rd, got, ex);
    vec++;
    if (ct_m_valid !== 1'b1 || ct_level !== LW'(3)) begin
      errs++; $display("FAIL rmid_pre: m_valid=%b level=%0d need 1/3", ct_m_valid, ct_level);
    end
    #2 rst = 1'b0;
    #1;
    vec++;
    if (ct_m_valid !== 1'b0 || ct_level !== '0 || sf_level !== '0) begin
      errs++; $display("FAIL rmid_async: ct_mv=%b ct_lvl=%0d sf_lvl=%0d need 0/0/0",
                       ct_m_valid, ct_level, sf_level);
    end
    q_ct.delete();
    q_sf.delete();
    @(negedge clk);
    rst = 1'b1;
    #1;
    vec++;
    if (ct_s_ready !== 1'b0) begin
      errs++; $display("FAIL rmid_ready_early: s_ready=%b need 0", ct_s_ready);
    end
    for (int c = 0; c < 20 && reads < 4; c++) begin
      step(1'b0, q_ct.size() + reads < 4, DW'(8'hE0 + c), c == 3, 1'b1, wr, rd, got, ex);
      if (c == 0) begin
        vec++;
        if ({ct_s_ready, sf_s_ready, ct_m_valid, sf_m_valid} !== 4'b1100) begin
          errs++; $display("FAIL rmid_release: sr/mv=%b need 1100",
                           {ct_s_ready, sf_s_ready, ct_m_valid, sf_m_valid});
        end
      end
      if (rd) begin
        reads++;
        vec++;
        if (got !== ex) begin
          errs++; $display("FAIL rmid_data read %0d: got %h need %h", reads, got, ex);
        end
      end
    end
    step(1'b0, 1'b0, '0, 1'b0, 1'b1, wr, rd, got, ex);
    vec++;
    if (reads !== 4 || rd !== 1'b0) begin
      errs++; $display("FAIL rmid_count: reads=%0d extra=%b need 4/0", reads, rd);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_cut_through();
    test_full();
    test_store_forward();
    test_oversize();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid();
    quiet();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axis_frame_fifo.md
AXIS_FRAME_FIFO -- requirements
Module: axis_frame_fifo

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 Parameter DATA_W SHALL default to 8 and set the payload width in bits (legal values 1 or more).
REQ-003 Parameter DEPTH SHALL default to 16 and set the storage entries (power of 2, 2 or more).
REQ-004 Parameter FRAME_MODE SHALL default to 0: 0 = cut-through, 1 = store-and-forward.
REQ-005 Port clk SHALL be an input, 1 bit wide: rising-edge clock.
REQ-006 Port rst SHALL be an input, 1 bit wide: asynchronous, active-low reset.
REQ-007 Port s_data SHALL be an input, DATA_W bits wide: slave payload.
REQ-008 Port s_valid SHALL be an input, 1 bit wide: slave beat valid.
REQ-009 Port s_ready SHALL be an output, 1 bit wide: block can accept a beat.
REQ-010 Port s_last SHALL be an input, 1 bit wide: final beat of a frame.
REQ-011 Port m_data SHALL be an output, DATA_W bits wide: master payload.
REQ-012 Port m_valid SHALL be an output, 1 bit wide: master beat valid.
REQ-013 Port m_ready SHALL be an input, 1 bit wide: downstream accepts the beat.
REQ-014 Port m_last SHALL be an output, 1 bit wide: final beat of a frame.
REQ-015 Port level SHALL be an output, clog2(DEPTH)+1 bits wide: stored beat count, range 0 to DEPTH.
REQ-016 Port frame_cnt SHALL be an output, clog2(DEPTH)+1 bits wide: complete frames held.
REQ-017 Port oversize SHALL be an output, 1 bit wide: one-cycle pulse when a frame exceeds DEPTH in FRAME_MODE=1.

Function
REQ-018 The block SHALL store {s_last, s_data} in a DEPTH-entry circular buffer with write and read pointers that wrap modulo DEPTH.
REQ-019 A write SHALL occur on a rising edge when s_valid=1 and s_ready=1.
REQ-020 A read SHALL occur on a rising edge when m_valid=1 and m_ready=1.
REQ-021 s_ready SHALL be registered and SHALL equal 1 exactly when the post-edge level is below DEPTH; there SHALL be no combinational path from m_ready or s_valid to s_ready.
REQ-022 m_data and m_last SHALL present the entry at the read pointer.
REQ-023 While m_valid=1 and m_ready=0, m_data and m_last SHALL hold stable.
REQ-024 In FRAME_MODE=0, m_valid SHALL be 1 whenever level is greater than 0.
REQ-025 In FRAME_MODE=0, a beat written at edge N SHALL be visible on m_* immediately after edge N, giving 1-cycle latency on an empty FIFO.
REQ-026 In FRAME_MODE=1, m_valid SHALL be 1 only when level>0 and either frame_cnt>0 or level=DEPTH.
REQ-027 Once the first beat of a frame is released in FRAME_MODE=1, m_valid SHALL stay asserted until that frame's m_last beat is read, whenever data is present.
REQ-028 level SHALL change by +1 on a write only, -1 on a read only, and 0 on a simultaneous write and read.
REQ-029 frame_cnt SHALL change by +1 on a write with s_last=1, -1 on a read with m_last=1, and 0 when both occur in the same cycle.
REQ-030 When full, s_ready SHALL be 0 and no write SHALL occur regardless of s_valid; a read in that cycle SHALL make s_ready=1 on the next cycle.
REQ-031 When empty, m_valid SHALL be 0 and m_ready SHALL be ignored.
REQ-032 oversize SHALL pulse for exactly one cycle when FRAME_MODE=1, level reaches DEPTH, and frame_cnt=0.
REQ-033 After an oversize pulse, the partial frame SHALL drain cut-through until its last beat, with no data lost or duplicated.
REQ-034 Back-to-back frames, including single-beat frames with s_last on the first beat, SHALL be supported with no idle cycle required between them.

Reset
REQ-035 On rst=0, the block SHALL asynchronously clear both pointers, level, frame_cnt, oversize, m_valid and s_ready to 0.
REQ-036 Storage contents SHALL NOT require reset.
REQ-037 s_ready SHALL rise to 1 on the first rising edge after rst returns to 1.
REQ-038 A reset asserted mid-frame SHALL discard all stored beats and frames, with m_valid=0 immediately and no partial frame emitted after release.

Verification
REQ-039 FRAME_MODE=0, m_ready=1, 8-beat frame with random data and s_last on beat 8 -> identical data out, each beat 1 cycle after write, m_last on beat 8, level never above 1.
REQ-040 FRAME_MODE=0, DEPTH=16, m_ready=0, 20 beats offered -> 16 accepted, s_ready=0 after the 16th, level=16; then m_ready=1 -> all 16 beats out in order, remaining 4 accepted.
REQ-041 FRAME_MODE=1, 8-beat frame with m_ready=1 -> m_valid stays 0 until the beat-8 write, frame_cnt=1, then 8 consecutive beats out and frame_cnt=0.
REQ-042 FRAME_MODE=1, DEPTH=16, 20-beat frame -> oversize pulses once at level=16, and all 20 beats are delivered in order with m_last on beat 20.
REQ-043 Simultaneous write and read at level=5, with s_last on the write and m_last on the read -> level stays 5 and frame_cnt is unchanged.
REQ-044 rst=0 asserted after 3 beats of a frame, then released -> m_valid=0 and level=0, s_ready=1 one edge after release, and the next frame passes uncorrupted.
